ddr3_pll_phase_stepper: RTL and testbench

// - Sequencer directly upstream of the DDR3 PLL's dynamic-phase port; drives phase_step/phase_updn and consumes phase_done.
// - Accepts "step N times up/down" requests from write-leveling/calibration logic and issues one PLL step at a time.
// - Runs each step through the PLL's done handshake and tracks the WDQ phase position modulo one clock period.

---
 rtl/ddr3_phase_pkg.sv | 16 +
 rtl/ddr3_phase_done_sync.sv | 33 +++
 rtl/ddr3_pll_phase_stepper.sv | 224 ++++++++++++++++++++++
 tb/tb_ddr3_pll_phase_stepper.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_phase_pkg.sv
// Shared types and helpers for the DDR3 PLL phase stepper.
package ddr3_phase_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PULSE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        SETTLE    = 3'd4
    } phase_state_t;

    function automatic int pos_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/ddr3_phase_done_sync.sv
// Two-flop synchronizer for the PLL phase_done flag; resets to 1 (PLL idle).
module ddr3_phase_done_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next-state of the two synchronizer stages.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Synchronizer flops, reset to the PLL-idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/ddr3_pll_phase_stepper.sv
// Issues "step N up/down" requests to the PLL dynamic-phase port one step at a time.
// Optional per-step done timeout: define PHASE_STEPPER_TIMEOUT_EN.
module ddr3_pll_phase_stepper
    import ddr3_phase_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 32,
    parameter int CNT_W           = 8,
    parameter int PULSE_CYCLES    = 2,
    parameter int SETTLE_CYCLES   = 4,
    parameter int DONE_TIMEOUT    = 1023
) (
    input  logic                              CLK_IN,
    input  logic                              RST_IN_N,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_updn,
    input  logic [CNT_W-1:0]                  req_count,
    output logic                              busy,
    output logic                              phase_step,
    output logic                              phase_updn,
    input  logic                              phase_done,
    output logic [pos_w(STEPS_PER_CYCLE)-1:0] phase_pos,
    output logic                              step_done,
    output logic                              err_timeout
);

    localparam int POS_W = pos_w(STEPS_PER_CYCLE);
    localparam int PC_W  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int ST_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [POS_W-1:0] POS_LAST    = POS_W'(STEPS_PER_CYCLE - 1);
    localparam logic [PC_W-1:0]  PULSE_LAST  = PC_W'(PULSE_CYCLES - 1);
    localparam logic [ST_W-1:0]  SETTLE_LAST = (SETTLE_CYCLES > 1) ? ST_W'(SETTLE_CYCLES - 1) : {ST_W{1'b0}};

    phase_state_t     state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [PC_W-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [ST_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             updn_q, updn_d;
    logic             step_q, step_d;
    logic             done_pulse_q, done_pulse_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_s;
    logic             accept_s;

    ddr3_phase_done_sync u_done_sync (
        .clk      (CLK_IN),
        .rst_n    (RST_IN_N),
        .async_in (phase_done),
        .sync_out (done_s)
    );

    assign accept_s = req_valid && (state_q == IDLE);

`ifdef PHASE_STEPPER_TIMEOUT_EN
    localparam int TO_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TMO_LAST = TO_W'(DONE_TIMEOUT - 1);

    logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            err_q, err_d;
    logic            tmo_hit_s;
    logic            tmo_abort_s;

    // Per-step done watchdog; an abort only fires when the step is not completing that cycle.
    always_comb begin
        if ((state_q == WAIT_ACK) || (state_q == WAIT_DONE)) begin
            tmo_cnt_d = tmo_cnt_q + TO_W'(1);
            tmo_hit_s = (tmo_cnt_q == TMO_LAST);
        end else begin
            tmo_cnt_d = {TO_W{1'b0}};
            tmo_hit_s = 1'b0;
        end
        tmo_abort_s = tmo_hit_s && (((state_q == WAIT_ACK) && done_s) ||
                                    ((state_q == WAIT_DONE) && !done_s));
        if (tmo_abort_s) begin
            err_d = 1'b1;
        end else if (accept_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge CLK_IN or negedge RST_IN_N) begin
        if (!RST_IN_N) begin
            tmo_cnt_q <= {TO_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    // Step sequencer: next state, counters and phase position.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        pulse_cnt_d  = pulse_cnt_q;
        settle_cnt_d = settle_cnt_q;
        pos_d        = pos_q;
        updn_d       = updn_q;
        done_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    updn_d      = req_updn;
                    remaining_d = req_count;
                    pulse_cnt_d = {PC_W{1'b0}};
                    if (req_count == {CNT_W{1'b0}}) begin
                        done_pulse_d = 1'b1;
                    end else begin
                        state_d = PULSE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    state_d = WAIT_ACK;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PC_W'(1);
                end
            end
            WAIT_ACK: begin
                // A high done here is the previous step's level, not an acknowledge.
                if (!done_s) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (done_s) begin
                    state_d      = SETTLE;
                    settle_cnt_d = {ST_W{1'b0}};
                    remaining_d  = remaining_q - CNT_W'(1);
                    if (updn_q) begin
                        pos_d = (pos_q == POS_LAST) ? {POS_W{1'b0}} : pos_q + POS_W'(1);
                    end else begin
                        pos_d = (pos_q == {POS_W{1'b0}}) ? POS_LAST : pos_q - POS_W'(1);
                    end
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    if (remaining_q != {CNT_W{1'b0}}) begin
                        state_d     = PULSE;
                        pulse_cnt_d = {PC_W{1'b0}};
                    end else begin
                        state_d      = IDLE;
                        done_pulse_d = 1'b1;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + ST_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef PHASE_STEPPER_TIMEOUT_EN
        if (tmo_abort_s) begin
            state_d      = IDLE;
            remaining_d  = {CNT_W{1'b0}};
            pos_d        = pos_q;
            done_pulse_d = 1'b1;
        end else begin
            done_pulse_d = done_pulse_d;
        end
`endif

        step_d  = (state_d == PULSE);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge CLK_IN or negedge RST_IN_N) begin
        if (!RST_IN_N) begin
            state_q      <= IDLE;
            remaining_q  <= {CNT_W{1'b0}};
            pulse_cnt_q  <= {PC_W{1'b0}};
            settle_cnt_q <= {ST_W{1'b0}};
            pos_q        <= {POS_W{1'b0}};
            updn_q       <= 1'b1;
            step_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            pulse_cnt_q  <= pulse_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            pos_q        <= pos_d;
            updn_q       <= updn_d;
            step_q       <= step_d;
            done_pulse_q <= done_pulse_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = ready_q;
    assign busy       = busy_q;
    assign phase_step = step_q;
    assign phase_updn = updn_q;
    assign phase_pos  = pos_q;
    assign step_done  = done_pulse_q;

endmodule

// File: tb/tb_ddr3_pll_phase_stepper.sv
// Scoreboard bench for ddr3_pll_phase_stepper with a behavioural PLL and position model.
module tb_ddr3_pll_phase_stepper;

    localparam int STEPS        = 32;
    localparam int PULSE_CYCLES = 2;

    typedef struct {
        int pulses;
        int final_pos;
        bit updn;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_updn;
    logic [7:0] req_count;
    logic       busy;
    logic       phase_step;
    logic       phase_updn;
    logic       pll_done;
    logic [4:0] phase_pos;
    logic       step_done;
    logic       err_timeout;

    int   n_total = 0;
    int   n_pass  = 0;
    int   model_pos = 0;
    bit   mon_en = 0;
    bit   pll_stall = 0;
    exp_t req_q[$];
    int   pos_q[$];

    ddr3_pll_phase_stepper dut (
        .CLK_IN      (clk),
        .RST_IN_N    (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_updn    (req_updn),
        .req_count   (req_count),
        .busy        (busy),
        .phase_step  (phase_step),
        .phase_updn  (phase_updn),
        .phase_done  (pll_done),
        .phase_pos   (phase_pos),
        .step_done   (step_done),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // PLL model: after each step pulse ends, done drops for 5 cycles then rises.
    initial begin
        pll_done = 1'b1;
        forever begin
            @(posedge clk iff phase_step);
            @(posedge clk iff !phase_step);
            if (!pll_stall) begin
                #1 pll_done = 1'b0;
                repeat (5) @(posedge clk);
                #1 pll_done = 1'b1;
            end
        end
    end

    // Monitor: checks pulse shape, each position change, and each request completion.
    int prev_pos;
    bit prev_step;
    bit prev_done;
    int pulse_w;
    int pulses_seen;
    always @(negedge clk) begin
        exp_t ep;
        int   p;
        if (!mon_en) begin
            pulse_w     = 0;
            pulses_seen = 0;
        end else begin
            if (phase_step && !prev_step) begin
                pulse_w = 1;
                if (req_q.size() > 0) check("updn_during_step", phase_updn, req_q[0].updn);
            end else if (phase_step) begin
                pulse_w++;
            end else if (prev_step) begin
                check("pulse_width", pulse_w, PULSE_CYCLES);
                pulses_seen++;
            end
            if (int'(phase_pos) != prev_pos) begin
                check("pos_change_expected", pos_q.size() > 0, 1);
                if (pos_q.size() > 0) begin
                    p = pos_q.pop_front();
                    check("pos_step", phase_pos, p);
                end
            end
            if (step_done) begin
                check("step_done_single", prev_done, 0);
                check("done_expected", req_q.size() > 0, 1);
                if (req_q.size() > 0) begin
                    ep = req_q.pop_front();
                    check("pulse_count", pulses_seen, ep.pulses);
                    check("final_pos", phase_pos, ep.final_pos);
                    check("pos_queue_drained", pos_q.size(), 0);
                end
                check("ready_with_done", req_ready, 1);
                check("busy_with_done", busy, 0);
                pulses_seen = 0;
            end
        end
        prev_step = phase_step;
        prev_pos  = int'(phase_pos);
        prev_done = step_done;
    end

    task automatic wait_idle(input int budget);
        int k = 0;
        while (k < budget && !(req_ready && req_q.size() == 0)) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("idle_within_budget", k < budget, 1);
    endtask

    task automatic send(input bit up, input int cnt, input bit stalled);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_updn  = up;
        req_count = 8'(cnt);
        e.updn = up;
        if (stalled) begin
            e.pulses = (cnt > 0) ? 1 : 0;
        end else begin
            e.pulses = cnt;
            for (int i = 0; i < cnt; i++) begin
                model_pos = up ? (model_pos + 1) % STEPS : (model_pos + STEPS - 1) % STEPS;
                pos_q.push_back(model_pos);
            end
        end
        e.final_pos = model_pos;
        req_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_updn  = 1'($urandom);
        req_count = 8'($urandom);
        if (cnt == 0) begin
            @(negedge clk);
            check("zero_count_done_next_cycle", step_done, 1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_updn  = 1'b0;
        req_count = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_phase_step", phase_step, 0);
        check("rst_phase_updn", phase_updn, 1);
        check("rst_phase_pos", phase_pos, 0);
        check("rst_step_done", step_done, 0);
        check("rst_err_timeout", err_timeout, 0);
        mon_en = 1;

        send(1'b1, 3, 1'b0);
        wait_idle(500);
        check("pos_after_up3", phase_pos, 3);
        send(1'b0, 2, 1'b0);
        wait_idle(500);
        send(1'b0, 3, 1'b0);
        wait_idle(500);
        check("pos_after_down_wrap", phase_pos, 30);

        send(1'b1, 0, 1'b0);
        wait_idle(50);
        check("pos_after_zero_count", phase_pos, 30);

        send(1'b1, 5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_updn  = 1'($urandom);
            req_count = 8'($urandom_range(1, 255));
            #1;
            check("ready_low_while_busy", req_ready, 0);
            check("busy_high", busy, 1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle(1000);
        send(1'b0, 4, 1'b0);
        wait_idle(1000);
        check("pos_after_second_req", phase_pos, model_pos);

        for (int i = 0; i < 12; i++) begin
            send(1'($urandom_range(0, 1)), $urandom_range(0, 40), 1'b0);
            wait_idle(2000);
            check("pos_random_req", phase_pos, model_pos);
        end

`ifdef PHASE_STEPPER_TIMEOUT_EN
        pll_stall = 1;
        send(1'b1, 3, 1'b1);
        wait_idle(1200);
        check("timeout_flag_set", err_timeout, 1);
        check("timeout_pos_unchanged", phase_pos, model_pos);
        pll_stall = 0;
        repeat (4) @(negedge clk);
        send(1'b1, 1, 1'b0);
        check("timeout_flag_cleared", err_timeout, 0);
        wait_idle(500);
`endif

        mon_en = 0;
        send(1'b1, 4, 1'b0);
        req_q.delete();
        pos_q.delete();
        check("step_high_before_reset", phase_step, 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_drops_step_async", phase_step, 0);
        check("reset_clears_pos", phase_pos, 0);
        check("reset_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_pos = 0;
        repeat (12) @(negedge clk);
        mon_en = 1;
        send(1'b1, 2, 1'b0);
        wait_idle(500);
        check("pos_after_reset_req", phase_pos, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
